// File: rtl/bsg_fsb_multi_channel_node.sv
// rtl/bsg_fsb_multi_channel_node.sv - FSB ring node multiplexing client channels onto one ring port
// Inbound packets are steered to per-channel FIFOs by tag; outbound sends are credit-gated round-robin.
module bsg_fsb_multi_channel_node #(
  parameter int ring_width_p   = 80,
  parameter int num_channels_p = 4,
  parameter int fifo_els_p     = 4,
  parameter int credits_p      = 8,
  parameter int dest_id_p      = 0,
  localparam int tag_w     = (num_channels_p > 1) ? $clog2(num_channels_p) : 1,
  localparam int payload_w = ring_width_p - 5 - tag_w
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  v_i,
  input  logic [ring_width_p-1:0]               data_i,
  output logic                                  ready_o,
  output logic                                  v_o,
  output logic [ring_width_p-1:0]               data_o,
  input  logic                                  yumi_i,
  output logic [num_channels_p-1:0]             ch_v_o,
  output logic [num_channels_p*payload_w-1:0]   ch_data_o,
  input  logic [num_channels_p-1:0]             ch_yumi_i,
  input  logic [num_channels_p-1:0]             ch_v_i,
  input  logic [num_channels_p*payload_w-1:0]   ch_data_i,
  output logic [num_channels_p-1:0]             ch_ready_o,
  output logic [7:0]                            drop_cnt_o,
  output logic                                  err_o
);

  localparam int cred_w = $clog2(credits_p + 1);
  localparam int ptr_w  = $clog2(fifo_els_p);
  localparam int cnt_w  = $clog2(fifo_els_p + 1);

  logic [tag_w-1:0]          in_tag, in_idx;
  logic                      in_cmd, tag_ok;
  logic [payload_w-1:0]      in_payload;
  logic                      unused_destid;
  logic [num_channels_p-1:0] full, enq, ret, send;

  logic [payload_w-1:0] mem    [num_channels_p][fifo_els_p];
  logic [ptr_w-1:0]     rd_ptr [num_channels_p];
  logic [ptr_w-1:0]     wr_ptr [num_channels_p];
  logic [cnt_w-1:0]     count  [num_channels_p];
  logic [cred_w-1:0]    credit [num_channels_p];
  logic [tag_w-1:0]     rr_ptr, grant;
  logic                 grant_v, out_free;

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(fifo_els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign in_tag        = data_i[ring_width_p-6 -: tag_w];
  assign in_cmd        = data_i[ring_width_p-5];
  assign in_payload    = data_i[payload_w-1:0];
  assign unused_destid = ^data_i[ring_width_p-1 -: 4];
  assign tag_ok        = (32'(in_tag) < 32'(num_channels_p));
  // Out-of-range tags are folded to 0 so array indexing stays in bounds; tag_ok gates their effect.
  assign in_idx        = tag_ok ? in_tag : '0;
  assign out_free      = !v_o || yumi_i;

  always_comb begin
    for (int c = 0; c < num_channels_p; c++) begin
      full[c]                              = (count[c] == cnt_w'(fifo_els_p));
      ch_v_o[c]                            = (count[c] != '0);
      ch_data_o[c*payload_w +: payload_w]  = mem[c][rd_ptr[c]];
    end
  end

  // A full FIFO can still take a packet when its head is being dequeued this cycle.
  always_comb begin
    ready_o = 1'b1;
    if (tag_ok && !in_cmd)
      ready_o = !full[in_idx] || ch_yumi_i[in_idx];
  end

  always_comb begin
    logic [tag_w:0]   sum;
    logic [tag_w-1:0] idx;
    sum        = '0;
    idx        = '0;
    grant      = '0;
    grant_v    = 1'b0;
    ch_ready_o = '0;
    for (int i = 0; i < num_channels_p; i++) begin
      sum = {1'b0, rr_ptr} + (tag_w+1)'(i);
      if (sum >= (tag_w+1)'(num_channels_p))
        sum = sum - (tag_w+1)'(num_channels_p);
      idx = sum[tag_w-1:0];
      if (out_free && !grant_v && ch_v_i[idx] && credit[idx] != '0) begin
        grant_v = 1'b1;
        grant   = idx;
      end
    end
    if (grant_v)
      ch_ready_o[grant] = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < num_channels_p; c++) begin
      enq[c]  = v_i && ready_o && tag_ok && !in_cmd && (in_idx == tag_w'(c));
      ret[c]  = v_i && tag_ok && in_cmd && (in_idx == tag_w'(c));
      send[c] = ch_v_i[c] && ch_ready_o[c];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_channels_p; c++)
      if (enq[c])
        mem[c][wr_ptr[c]] <= in_payload;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < num_channels_p; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
        credit[c] <= cred_w'(credits_p);
      end
      rr_ptr     <= '0;
      v_o        <= 1'b0;
      data_o     <= '0;
      drop_cnt_o <= '0;
      err_o      <= 1'b0;
    end else begin
      for (int c = 0; c < num_channels_p; c++) begin
        if (enq[c])
          wr_ptr[c] <= next_ptr(wr_ptr[c]);
        if (ch_yumi_i[c])
          rd_ptr[c] <= next_ptr(rd_ptr[c]);
        count[c] <= count[c] + cnt_w'(enq[c]) - cnt_w'(ch_yumi_i[c]);
        // A return and a send on the same channel cancel out.
        if (ret[c] && !send[c]) begin
          if (credit[c] == cred_w'(credits_p))
            err_o <= 1'b1;
          else
            credit[c] <= credit[c] + cred_w'(1);
        end else if (send[c] && !ret[c]) begin
          credit[c] <= credit[c] - cred_w'(1);
        end
      end
      if (v_i && !tag_ok && drop_cnt_o != 8'hff)
        drop_cnt_o <= drop_cnt_o + 8'd1;
      if (grant_v) begin
        v_o    <= 1'b1;
        data_o <= {4'(dest_id_p), 1'b0, grant, ch_data_i[grant*payload_w +: payload_w]};
        rr_ptr <= (grant == tag_w'(num_channels_p - 1)) ? '0 : grant + tag_w'(1);
      end else if (yumi_i) begin
        v_o <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
  assert property (@(posedge clk_i) disable iff (reset_i) (ch_yumi_i & ~ch_v_o) == '0);

endmodule

// File: tb/tb_bsg_fsb_multi_channel_node.sv
// tb/tb_bsg_fsb_multi_channel_node.sv - randomized bench with queue-based reference model
// A second instance with five channels exercises out-of-range tag handling.
module tb_bsg_fsb_multi_channel_node;
  localparam int n  = 4;
  localparam int rw = 80;
  localparam int pw = 73;
  localparam int tw = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            r_v, ready, v_o, r_yumi, err;
  logic [rw-1:0]   r_data, data_o;
  logic [n-1:0]    ch_v_o, c_yumi, c_v, ch_ready;
  logic [n*pw-1:0] ch_data_o, c_data;
  logic [7:0]      drop;

  logic          v5, ready5, vo5, err5;
  logic [rw-1:0] d5, do5;
  logic [4:0]    chv5, chr5;
  logic [359:0]  chd5;
  logic [7:0]    drop5;

  bsg_fsb_multi_channel_node #(.num_channels_p(4)) dut (
    .clk_i(clk), .reset_i(rst), .v_i(r_v), .data_i(r_data), .ready_o(ready),
    .v_o(v_o), .data_o(data_o), .yumi_i(r_yumi), .ch_v_o(ch_v_o), .ch_data_o(ch_data_o),
    .ch_yumi_i(c_yumi), .ch_v_i(c_v), .ch_data_i(c_data), .ch_ready_o(ch_ready),
    .drop_cnt_o(drop), .err_o(err));

  bsg_fsb_multi_channel_node #(.num_channels_p(5)) dut5 (
    .clk_i(clk), .reset_i(rst), .v_i(v5), .data_i(d5), .ready_o(ready5),
    .v_o(vo5), .data_o(do5), .yumi_i(1'b0), .ch_v_o(chv5), .ch_data_o(chd5),
    .ch_yumi_i(5'b0), .ch_v_i(5'b0), .ch_data_i(360'b0), .ch_ready_o(chr5),
    .drop_cnt_o(drop5), .err_o(err5));

  logic [pw-1:0] qm [n][4];
  int            qn [n];
  int            cred [n];
  int            rr, m_drop, checks, errors, s;
  bit            m_err, m_v;
  logic [rw-1:0] m_data;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    if (m_v && !r_yumi) return -1;
    for (int i = 0; i < n; i++) begin
      int c = (rr + i) % n;
      if (c_v[c] && cred[c] > 0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < n; c++) begin
      qn[c]   = 0;
      cred[c] = 8;
    end
    rr = 0; m_drop = 0; m_err = 0; m_v = 0; m_data = '0;
  endtask

  task automatic cycle();
    int g;
    logic [tw-1:0] t;
    bit cmd, exp_ready, rt, sd;
    for (int c = 0; c < n; c++) if (qn[c] == 0) c_yumi[c] = 1'b0;
    if (!m_v) r_yumi = 1'b0;
    #1;
    t = r_data[rw-6 -: tw];
    cmd = r_data[rw-5];
    exp_ready = cmd || (qn[t] < 4) || c_yumi[t];
    g = pick();
    check("ready_o", ready, exp_ready);
    check("ch_ready_o", ch_ready, (g < 0) ? 0 : (1 << g));
    check("v_o", v_o, m_v);
    if (m_v) check("data_o", data_o, m_data);
    check("drop_cnt_o", drop, m_drop);
    check("err_o", err, m_err);
    for (int c = 0; c < n; c++) begin
      check("ch_v_o", ch_v_o[c], qn[c] != 0);
      if (qn[c] != 0) check("ch_data_o", ch_data_o[c*pw +: pw], qm[c][0]);
    end
    for (int c = 0; c < n; c++)
      if (c_yumi[c]) begin
        for (int i = 0; i < qn[c] - 1; i++) qm[c][i] = qm[c][i+1];
        qn[c]--;
      end
    if (r_v && exp_ready && !cmd) begin
      qm[t][qn[t]] = r_data[pw-1:0];
      qn[t]++;
    end
    for (int c = 0; c < n; c++) begin
      rt = r_v && cmd && (t == c);
      sd = (g == c);
      if (rt && !sd) begin
        if (cred[c] == 8) m_err = 1; else cred[c]++;
      end else if (sd && !rt) cred[c]--;
    end
    if (g >= 0) begin
      m_v = 1;
      m_data = {4'h0, 1'b0, 2'(g), c_data[g*pw +: pw]};
      rr = (g + 1) % n;
    end else if (r_yumi) m_v = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    r_v = 0; r_yumi = 0; c_yumi = '0; c_v = '0; v5 = 0;
    #1;
    check("rst_v_o", v_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_ch_v_o", ch_v_o, 0);
    check("rst_drop", drop, 0);
    check("rst_err", err, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_data();
    for (int c = 0; c < n; c++) c_data[c*pw +: pw] = pw'({$urandom, $urandom, $urandom});
  endtask

  task automatic run_sends(input logic [n-1:0] mask, input int cycles, output int sent);
    sent = 0;
    for (int k = 0; k < cycles; k++) begin
      c_v = mask; r_yumi = 1'b1; rand_data();
      cycle();
      if (v_o) sent++;
    end
    c_v = '0;
  endtask

  task automatic rand_cycles(input int cycles);
    bit cmd;
    for (int k = 0; k < cycles; k++) begin
      cmd = ($urandom % 3) == 0;
      r_v = ($urandom % 2) == 1;
      r_data = {4'($urandom), cmd, 2'($urandom), pw'({$urandom, $urandom, $urandom})};
      r_yumi = ($urandom % 10) < 7;
      c_yumi = 4'($urandom);
      c_v = 4'($urandom);
      rand_data();
      cycle();
    end
    r_v = 0; c_yumi = '0; c_v = '0; r_yumi = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    r_v = 0; r_data = '0; r_yumi = 0; c_yumi = '0; c_v = '0; c_data = '0;
    v5 = 0; d5 = '0;
    @(negedge clk);
    do_reset();

    r_v = 1; r_data = {4'h0, 1'b0, 2'd2, 73'h1234};
    cycle();
    r_v = 0;
    check("t2_ch_v", ch_v_o, 4'b0100);
    check("t2_data", ch_data_o[2*pw +: pw], 73'h1234);
    c_yumi = 4'b0100;
    cycle();
    c_yumi = '0;
    check("t2_cleared", ch_v_o, 0);

    for (int i = 0; i < 4; i++) begin
      r_v = 1; r_data = {4'h0, 1'b0, 2'd1, pw'(i + 16)};
      cycle();
    end
    r_v = 0; #1;
    check("t3_full_rdy1", ready, 0);
    r_data = {4'h0, 1'b0, 2'd0, 73'h0}; #1;
    check("t3_rdy0", ready, 1);
    r_v = 1; r_data = {4'h0, 1'b0, 2'd1, 73'd99}; c_yumi = 4'b0010; #1;
    check("t3_rdy_yumi", ready, 1);
    cycle();
    r_v = 0;
    repeat (4) cycle();
    c_yumi = '0;
    check("t3_drained", ch_v_o, 0);

    v5 = 1; d5 = {4'h0, 1'b0, 3'd5, 72'hAB}; #1;
    check("t6_rdy_bad", ready5, 1);
    @(negedge clk);
    check("t6_drop1", drop5, 1);
    check("t6_no_enq", chv5, 0);
    d5 = {4'h0, 1'b0, 3'd4, 72'hCD};
    @(negedge clk);
    check("t6_enq4", chv5, 5'b10000);
    check("t6_data4", chd5[4*72 +: 72], 72'hCD);
    d5 = {4'h0, 1'b1, 3'd2, 72'h0};
    @(negedge clk);
    check("t6_err5", err5, 1);
    d5 = {4'h0, 1'b0, 3'd7, 72'h0};
    repeat (300) @(negedge clk);
    check("t6_drop_sat", drop5, 255);
    v5 = 0;

    do_reset();
    for (int k = 0; k < 12; k++) begin
      c_v = 4'hf; r_yumi = 1'b1; rand_data();
      cycle();
      check("t4_v", v_o, 1);
      check("t4_tag", data_o[74:73], k % 4);
    end
    c_v = '0;

    do_reset();
    run_sends(4'b0001, 12, s);
    check("t5_sends", s, 8);
    c_v = 4'b0001; #1;
    check("t5_blocked", ch_ready, 0);
    c_v = '0; r_v = 1; r_data = {4'h0, 1'b1, 2'd0, 73'h0};
    cycle();
    r_v = 0;
    run_sends(4'b0001, 5, s);
    check("t5_one_more", s, 1);

    r_v = 1; r_data = {4'h0, 1'b1, 2'd3, 73'h0};
    cycle();
    r_v = 0;
    check("t6_err", err, 1);
    run_sends(4'b1000, 10, s);
    check("t6_cred_held", s, 8);

    do_reset();
    rand_cycles(600);
    rand_cycles(7);
    r_yumi = 0;
    do_reset();
    rand_cycles(150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
